// File: rtl/cp_inserter_if.sv
// cp_inserter_if: AXI-Stream bundle for the cyclic-prefix inserter sample ports
interface cp_inserter_if #(
  parameter int DW = 32,
  parameter int UW = 2
) ();
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/cp_inserter.sv
// cp_inserter: ping-pong symbol buffer that prepends the cyclic prefix to each IFFT output symbol
module cp_inserter #(
  parameter int IN_DW = 32,
  parameter int NFFT = 8,
  parameter int CP_LEN = 18,
  parameter int CP_LEN_LONG = 20,
  parameter int SYMS_PER_SLOT = 14,
  parameter int LONG_CP_PERIOD = 7
) (
  input logic clk_i,
  input logic reset_i,
  cp_inserter_if.slave s_axis_in,
  cp_inserter_if.master m_axis_out,
  output logic [$clog2(SYMS_PER_SLOT)-1:0] sym_idx_o,
  output logic framing_error_o
);
  localparam int FFT_LEN = 2 ** NFFT;
  localparam int SW = $clog2(SYMS_PER_SLOT);
  localparam int BW = SW + 3 + IN_DW;
  localparam logic [NFFT-1:0] LAST = NFFT'(FFT_LEN - 1);
  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;
  state_t state;
  logic [IN_DW-1:0] mem [2][FFT_LEN];
  logic [IN_DW-1:0] q;
  logic [1:0] full;
  logic wr_bank, rd_bank, p1_v, p1_first, p1_slot, p1_last, s_v, out_v;
  logic [NFFT-1:0] wr_idx, ptr, cp_start, rd_addr;
  logic [SW-1:0] sym_idx, p1_sym;
  logic [BW-1:0] p1_beat, s_beat, out_beat;
  logic wr_fire, wr_last, avail, out_load, issue, fin;
  assign s_axis_in.tready = !full[wr_bank] && !reset_i;
  assign wr_fire = s_axis_in.tvalid && s_axis_in.tready;
  assign wr_last = wr_idx == LAST;
  // a bank completing this very cycle may start reading at once; its last sample is not in the prefix head
  assign avail = full[rd_bank] || (wr_fire && wr_last && wr_bank == rd_bank);
  assign cp_start = 32'(sym_idx) % LONG_CP_PERIOD == 0 ? NFFT'(FFT_LEN - CP_LEN_LONG) : NFFT'(FFT_LEN - CP_LEN);
  assign rd_addr = state == IDLE ? cp_start : ptr;
  assign fin = state == BODY && ptr == LAST;
  assign out_load = !out_v || m_axis_out.tready;
  // at most one beat may wait in the skid register, so stop reading when it would be needed twice
  assign issue = !s_v && !(p1_v && !out_load) && (state != IDLE || avail);
  assign p1_beat = {p1_sym, p1_last, p1_slot, p1_first, q};
  assign {sym_idx_o, m_axis_out.tlast, m_axis_out.tuser, m_axis_out.tdata} = out_beat;
  assign m_axis_out.tvalid = out_v;
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_bank][wr_idx] <= s_axis_in.tdata;
    if (issue) q <= (wr_fire && wr_bank == rd_bank && wr_idx == rd_addr) ? s_axis_in.tdata : mem[rd_bank][rd_addr];
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx <= '0;
      ptr <= '0;
      sym_idx <= '0;
      p1_v <= 1'b0;
      s_v <= 1'b0;
      out_v <= 1'b0;
      out_beat <= '0;
      framing_error_o <= 1'b0;
    end else begin
      framing_error_o <= wr_fire && (s_axis_in.tlast != wr_last);
      if (wr_fire) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank <= !wr_bank;
        end
      end
      p1_v <= issue;
      if (issue) begin
        ptr <= rd_addr + 1'b1;
        state <= state == IDLE ? (cp_start == LAST ? BODY : CP) : (state == CP && ptr == LAST) ? BODY : fin ? IDLE : state;
        p1_first <= state == IDLE;
        p1_slot <= state == IDLE && sym_idx == '0;
        p1_last <= fin;
        p1_sym <= sym_idx;
        if (fin) begin
          full[rd_bank] <= 1'b0;
          rd_bank <= !rd_bank;
          sym_idx <= sym_idx == SW'(SYMS_PER_SLOT - 1) ? '0 : sym_idx + 1'b1;
        end
      end
      if (p1_v && !out_load) begin
        s_v <= 1'b1;
        s_beat <= p1_beat;
      end else if (out_load) s_v <= 1'b0;
      if (out_load) begin
        out_v <= s_v || p1_v;
        if (s_v || p1_v) out_beat <= s_v ? s_beat : p1_beat;
      end
    end
  end
endmodule

// File: tb/tb_cp_inserter.sv
// tb_cp_inserter: randomized scoreboard bench comparing CP-prefixed output to a symbol-level model
module tb_cp_inserter;
  localparam int N = 256;
  typedef logic [38:0] beat_t;
  logic clk = 0, rst = 1;
  logic [3:0] sym_idx;
  logic fe;
  always #5 clk = ~clk;
  cp_inserter_if #(.DW(32), .UW(1)) in_if ();
  cp_inserter_if #(.DW(32), .UW(2)) out_if ();
  cp_inserter dut (
    .clk_i(clk), .reset_i(rst), .s_axis_in(in_if.slave), .m_axis_out(out_if.master),
    .sym_idx_o(sym_idx), .framing_error_o(fe)
  );
  beat_t exp_q[$];
  logic [31:0] part[$];
  beat_t act, snap;
  bit stall = 0, abort = 0, gap_watch = 0;
  int checks = 0, fails = 0, cyc = 0, rdy_mode = 0, gaps = 0, acc = 0;
  int fe_exp = 0, fe_seen = 0, out_sym = 0, out_beat = 0, last_in_cyc = 0, msym = 0, cp = 0, c = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_if.tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom_range(1));
  end

  // reference model: each completed symbol expands to its prefix tail followed by the full body
  always @(negedge clk) begin
    if (rst) begin
      part.delete();
      exp_q.delete();
      msym = 0;
    end else if (in_if.tvalid && in_if.tready) begin
      acc++;
      fe_exp += int'(in_if.tlast != (part.size() == N - 1));
      part.push_back(in_if.tdata);
      if (part.size() == N) begin
        cp = (msym % 7 == 0) ? 20 : 18;
        for (int k = N - cp; k < N; k++)
          exp_q.push_back({4'(msym), 1'b0, (k == N - cp) ? {msym == 0, 1'b1} : 2'b00, part[k]});
        for (int k = 0; k < N; k++)
          exp_q.push_back({4'(msym), k == N - 1, 2'b00, part[k]});
        msym = (msym + 1) % 14;
        part.delete();
        last_in_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (fe) fe_seen++;
    if (rst) begin
      stall = 0;
      out_sym = 0;
      out_beat = 0;
    end else begin
      act = {sym_idx, out_if.tlast, out_if.tuser, out_if.tdata};
      if (stall) check("stall_hold", act, snap);
      if (gap_watch && !out_if.tvalid && exp_q.size() > 0) gaps++;
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_beat: got %0h expected no beat", act);
        end else check("beat", act, exp_q.pop_front());
        out_beat++;
        if (out_if.tlast) begin
          out_sym++;
          out_beat = 0;
        end
      end
      stall = out_if.tvalid && !out_if.tready;
      snap = act;
    end
  end

  task automatic send_sample(input logic [31:0] d, input bit l, input int pv);
    int t = 0;
    bit hs = 0;
    while (!abort && $urandom_range(99) >= pv) begin
      @(posedge clk);
      #1;
    end
    in_if.tdata = d;
    in_if.tlast = l;
    in_if.tvalid = 1;
    while (!hs && !abort && t < 4000) begin
      @(negedge clk);
      hs = in_if.tready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!hs && !abort) begin
      checks++;
      fails++;
      $display("FAIL in_timeout: tready low for %0d cycles, expected accept", t);
    end
    in_if.tvalid = 0;
  endtask

  task automatic send_syms(input int n, input int pv, input int bad_s, input int bad_i, input bit ramp);
    for (int s = 0; s < n && !abort; s++)
      for (int i = 0; i < N && !abort; i++)
        send_sample(ramp ? 32'(i) : $urandom(), (i == N - 1) || (s == bad_s && i == bad_i), pv);
  endtask

  task automatic wait_valid(output int cv);
    int t = 0;
    @(negedge clk);
    while (!out_if.tvalid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("first_valid_seen", out_if.tvalid, 1);
    cv = cyc;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("idle_valid", out_if.tvalid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    acc = 0;
    fe_exp = 0;
    fe_seen = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.tvalid = 0;
    in_if.tdata = 0;
    in_if.tlast = 0;
    in_if.tuser = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_tready", in_if.tready, 0);
    check("rst_tvalid", out_if.tvalid, 0);
    check("rst_tuser", out_if.tuser, 0);
    check("rst_tlast", out_if.tlast, 0);
    check("rst_tdata", out_if.tdata, 0);
    check("rst_sym_idx", sym_idx, 0);
    check("rst_framing", fe, 0);
    @(posedge clk);
    #1;
    rst = 0;
    fork
      send_syms(1, 100, -1, 0, 1);
      wait_valid(c);
    join
    check("t1_latency", c - last_in_cyc, 2);
    drain();
    check("t1_syms", out_sym, 1);
    do_reset();
    gaps = 0;
    fork
      send_syms(15, 100, -1, 0, 1);
      begin
        wait_valid(c);
        gap_watch = 1;
      end
    join
    drain();
    gap_watch = 0;
    check("t2_gaps", gaps, 0);
    check("t2_syms", out_sym, 15);
    do_reset();
    rdy_mode = 1;
    fork
      send_syms(3, 100, -1, 0, 0);
      begin
        repeat (900) @(negedge clk);
        check("t3_accepted", acc, 512);
        check("t3_in_tready", in_if.tready, 0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain();
    check("t3_syms", out_sym, 3);
    do_reset();
    rdy_mode = 2;
    send_syms(28, 50, -1, 0, 0);
    rdy_mode = 0;
    drain();
    check("t4_syms", out_sym, 28);
    do_reset();
    send_syms(3, 100, 2, 100, 1);
    drain();
    check("t5_fe_model", fe_seen, fe_exp);
    check("t5_fe_once", fe_seen, 1);
    check("t5_syms", out_sym, 3);
    do_reset();
    fork
      send_syms(6, 100, -1, 0, 0);
      begin
        int t = 0;
        while (!(out_sym == 3 && out_beat == 50) && t < 5000) begin
          @(negedge clk);
          t++;
        end
        check("t6_reached_beat", out_beat, 50);
        @(posedge clk);
        #1;
        rst = 1;
        abort = 1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_tvalid", out_if.tvalid, 0);
        check("t6_rst_in_tready", in_if.tready, 0);
        @(posedge clk);
        #1;
        rst = 0;
      end
    join
    abort = 0;
    send_syms(1, 100, -1, 0, 0);
    drain();
    check("t6_syms", out_sym, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
